// File: rtl/minhash_pair_streamer.sv
// Purpose: stores two MinHash signatures (first / second DNA sequence) written
// entry-by-entry, then replays them in lock-step as aligned pairs, one hash
// index per clock, for a downstream similarity counter.
// Ports:
//   clk, rstN            clock; synchronous active-high reset
//   wrEn/wrSel/wrIdx/wrData  entry write (IDLE only; wrSel 0 = first bank)
//   start                request to stream a fully loaded pair of signatures
//   busy                 state is STREAM or DONE
//   outValid/outFirst/outSecond/outLast  registered pair stream
//   done                 one-cycle pulse after the last pair
//   startErr             sticky: start seen with an incomplete load
//   wrDropped            sticky: write issued while busy
module minhash_pair_streamer #(
  parameter int unsigned NUM_HASH = 16,
  parameter int unsigned VAL_W    = 32
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        wrEn,
  input  logic                        wrSel,
  input  logic [$clog2(NUM_HASH)-1:0] wrIdx,
  input  logic [VAL_W-1:0]            wrData,
  input  logic                        start,
  output logic                        busy,
  output logic                        outValid,
  output logic [VAL_W-1:0]            outFirst,
  output logic [VAL_W-1:0]            outSecond,
  output logic                        outLast,
  output logic                        done,
  output logic                        startErr,
  output logic                        wrDropped
);

  localparam int unsigned IDX_W = $clog2(NUM_HASH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [VAL_W-1:0]    bank_a [NUM_HASH];
  logic [VAL_W-1:0]    bank_b [NUM_HASH];
  logic [NUM_HASH-1:0] mask_a, mask_b;

  logic             valid_nxt, last_nxt, done_nxt;
  logic [VAL_W-1:0] first_nxt, second_nxt;
  logic             start_err_nxt, clear_masks, wr_ok, wr_drop;

  // Writes land only in IDLE; out-of-range indices are silently ignored.
  assign wr_ok   = wrEn && (state == IDLE) && (32'(wrIdx) < NUM_HASH);
  assign wr_drop = wrEn && (state != IDLE);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    valid_nxt     = 1'b0;
    last_nxt      = 1'b0;
    done_nxt      = 1'b0;
    first_nxt     = '0;
    second_nxt    = '0;
    start_err_nxt = 1'b0;
    clear_masks   = 1'b0;
    case (state)
      IDLE: begin
        // Completeness uses the masks as they stand at the start of the cycle.
        if (start) begin
          if ((&mask_a) && (&mask_b)) begin
            state_nxt = STREAM;
            idx_nxt   = '0;
          end else begin
            start_err_nxt = 1'b1;
          end
        end
      end
      STREAM: begin
        valid_nxt  = 1'b1;
        first_nxt  = bank_a[idx];
        second_nxt = bank_b[idx];
        last_nxt   = (idx == IDX_W'(NUM_HASH - 1));
        idx_nxt    = idx + IDX_W'(1);
        if (last_nxt) state_nxt = DONE;
      end
      DONE: begin
        done_nxt    = 1'b1;
        clear_masks = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, control and registered outputs.
  always_ff @(posedge clk) begin
    if (rstN) begin
      state     <= IDLE;
      idx       <= '0;
      mask_a    <= '0;
      mask_b    <= '0;
      busy      <= 1'b0;
      outValid  <= 1'b0;
      outFirst  <= '0;
      outSecond <= '0;
      outLast   <= 1'b0;
      done      <= 1'b0;
      startErr  <= 1'b0;
      wrDropped <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      busy      <= (state_nxt != IDLE);
      outValid  <= valid_nxt;
      outFirst  <= first_nxt;
      outSecond <= second_nxt;
      outLast   <= last_nxt;
      done      <= done_nxt;
      startErr  <= startErr | start_err_nxt;
      wrDropped <= wrDropped | wr_drop;
      if (clear_masks) begin
        mask_a <= '0;
        mask_b <= '0;
      end else if (wr_ok) begin
        if (wrSel) mask_b[wrIdx] <= 1'b1;
        else       mask_a[wrIdx] <= 1'b1;
      end
    end
  end

  // Signature storage; contents are don't-care after reset, only masks matter.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wrSel) bank_b[wrIdx] <= wrData;
      else       bank_a[wrIdx] <= wrData;
    end
  end

endmodule

// File: tb/tb_minhash_pair_streamer.sv
// Purpose: self-checking bench for minhash_pair_streamer. A behavioural model
// keeps the expected signature contents, loaded flags and sticky flags; each
// stream is compared pair-by-pair against the model.
module tb_minhash_pair_streamer;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rstN, wrEn, wrSel, start;
  logic [IDX_W-1:0] wrIdx;
  logic [31:0]      wrData;
  logic             busy, outValid, outLast, done, startErr, wrDropped;
  logic [31:0]      outFirst, outSecond;

  minhash_pair_streamer #(.NUM_HASH(N), .VAL_W(32)) dut (
    .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrSel(wrSel), .wrIdx(wrIdx),
    .wrData(wrData), .start(start), .busy(busy), .outValid(outValid),
    .outFirst(outFirst), .outSecond(outSecond), .outLast(outLast),
    .done(done), .startErr(startErr), .wrDropped(wrDropped)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_a [N];
  logic [31:0] m_b [N];
  bit          m_la [N];
  bit          m_lb [N];
  bit          m_start_err, m_wr_dropped;
  int          eq_count;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < int'(N); i++) f = f & m_la[i] & m_lb[i];
    return f;
  endfunction

  task automatic model_clear_masks();
    for (int i = 0; i < int'(N); i++) begin
      m_la[i] = 1'b0;
      m_lb[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b1;
    tick();
    rstN = 1'b0;
    model_clear_masks();
    m_start_err  = 1'b0;
    m_wr_dropped = 1'b0;
  endtask

  // Write while the DUT is known to be idle; model tracks it.
  task automatic wr(input bit sel, input int idx, input logic [31:0] data);
    wrEn = 1'b1; wrSel = sel; wrIdx = IDX_W'(idx); wrData = data;
    tick();
    wrEn = 1'b0;
    if (sel) begin m_b[idx] = data; m_lb[idx] = 1'b1; end
    else     begin m_a[idx] = data; m_la[idx] = 1'b1; end
  endtask

  task automatic load_random();
    for (int i = 0; i < int'(N); i++) begin
      wr(1'b0, i, $urandom);
      wr(1'b1, i, $urandom);
    end
  endtask

  // Pulse start and check the whole transaction against the model.
  // inject_at: pair index during which a dropped write is issued (-1 none).
  // rst_at: pair index after which reset is pulsed (-1 none).
  task automatic run_stream(input int inject_at, input int rst_at,
                            input bit co_write, input logic [31:0] co_data);
    bit ok;
    ok = model_full();
    start = 1'b1;
    if (co_write) begin
      wrEn = 1'b1; wrSel = 1'b0; wrIdx = '0; wrData = co_data;
    end
    tick();
    start = 1'b0;
    wrEn  = 1'b0;
    if (co_write) begin m_a[0] = co_data; m_la[0] = 1'b1; end
    eq_count = 0;
    if (!ok) begin
      m_start_err = 1'b1;
      chk("start_err_set", 32'(startErr), 32'(m_start_err));
      for (int k = 0; k < int'(N) + 4; k++) begin
        chk("no_stream_valid", 32'(outValid), 32'd0);
        tick();
      end
      chk("no_stream_busy", 32'(busy), 32'd0);
      return;
    end
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("valid_latency", 32'(outValid), 32'd0);
    for (int i = 0; i < int'(N); i++) begin
      if (i == inject_at) begin
        wrEn = 1'b1; wrSel = 1'b0; wrIdx = IDX_W'(3); wrData = 32'hDEAD;
        m_wr_dropped = 1'b1;
      end
      tick();
      wrEn = 1'b0;
      chk($sformatf("valid[%0d]", i), 32'(outValid), 32'd1);
      chk($sformatf("first[%0d]", i), outFirst, m_a[i]);
      chk($sformatf("second[%0d]", i), outSecond, m_b[i]);
      chk($sformatf("last[%0d]", i), 32'(outLast), 32'(i == int'(N) - 1));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      chk($sformatf("done_early[%0d]", i), 32'(done), 32'd0);
      if (outValid && outFirst == outSecond) eq_count++;
      if (i == rst_at) begin
        do_reset();
        for (int k = 0; k < 3; k++) begin
          chk("abort_valid", 32'(outValid), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_last", 32'(outLast), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_first", outFirst, 32'd0);
          tick();
        end
        return;
      end
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(outValid), 32'd0);
    chk("done_first", outFirst, 32'd0);
    chk("done_second", outSecond, 32'd0);
    chk("done_last", 32'(outLast), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    model_clear_masks();
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("start_err_flag", 32'(startErr), 32'(m_start_err));
    chk("wr_dropped_flag", 32'(wrDropped), 32'(m_wr_dropped));
  endtask

  initial begin
    rstN = 1'b1; wrEn = 1'b0; wrSel = 1'b0; wrIdx = '0; wrData = '0; start = 1'b0;
    tick();
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_first", outFirst, 32'd0);
    chk("rst_second", outSecond, 32'd0);
    chk("rst_last", 32'(outLast), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start_err", 32'(startErr), 32'd0);
    chk("rst_wr_dropped", 32'(wrDropped), 32'd0);

    // Identity signatures
    for (int i = 0; i < int'(N); i++) begin
      wr(1'b0, i, 32'(i));
      wr(1'b1, i, 32'(i));
    end
    run_stream(-1, -1, 1'b0, '0);
    chk("identity_eq", 32'(eq_count), 32'd16);

    // Half-matching signatures
    for (int i = 0; i < int'(N); i++) begin
      wr(1'b0, i, 32'(i));
      wr(1'b1, i, (i % 2 == 0) ? 32'(i) : 32'(i + 100));
    end
    run_stream(-1, -1, 1'b0, '0);
    chk("half_eq", 32'(eq_count), 32'd8);

    // Incomplete load, then completion
    for (int i = 0; i < int'(N); i++) begin
      wr(1'b0, i, $urandom);
      if (i != 7) wr(1'b1, i, $urandom);
    end
    run_stream(-1, -1, 1'b0, '0);
    wr(1'b1, 7, $urandom);
    run_stream(-1, -1, 1'b0, '0);
    chk("start_err_sticky", 32'(startErr), 32'd1);

    // Dropped write during stream, then start without reload
    do_reset();
    load_random();
    run_stream(5, -1, 1'b0, '0);
    chk("wr_dropped_set", 32'(wrDropped), 32'd1);
    run_stream(-1, -1, 1'b0, '0);
    chk("reload_needed", 32'(startErr), 32'd1);

    // Reset mid-stream, then immediate start
    do_reset();
    load_random();
    run_stream(-1, 8, 1'b0, '0);
    chk("abort_start_err_clr", 32'(startErr), 32'd0);
    run_stream(-1, -1, 1'b0, '0);
    chk("abort_masks_cleared", 32'(startErr), 32'd1);

    // Overwrites and a write coinciding with start
    do_reset();
    wr(1'b0, 15, 32'h1);
    wr(1'b0, 15, 32'h2);
    for (int i = 0; i < int'(N); i++) begin
      if (i != 15) wr(1'b0, i, $urandom);
      wr(1'b1, i, $urandom);
    end
    run_stream(-1, -1, 1'b1, 32'h55);
    chk("model_last_wins", m_a[15], 32'h2);
    chk("start_err_clean", 32'(startErr), 32'd0);

    // Random full streams
    for (int r = 0; r < 3; r++) begin
      load_random();
      run_stream(-1, -1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/minhash_pair_streamer.md
Name: minhash_pair_streamer

Overview:
- Holds two MinHash signatures (first and second DNA sequence), each NUM_HASH minimum values, written entry-by-entry by the min-value stage.
- On start, replays both signatures in lock-step as aligned pairs, one hash index per clock, for the downstream similarity counter.
- It is the transmitting end of the per-cycle min-value pair interface: it drives aligned first/second values, validity and end-of-signature.

Parameters:
- NUM_HASH, 16, hash functions per signature; one entry per sequence per index. Legal range 2..31.
- VAL_W, 32, width of one min-hash value.
- IDX_W, $clog2(NUM_HASH), index width (derived; not overridden).

Ports:
- clk  input  1  global clock for the whole design.
- rstN  input  1  reset. Reset is synchronous and active-high. The port is named as in the codebase; asserted = 1.
- wrEn  input  1  write strobe for one signature entry.
- wrSel  input  1  0 = first-sequence bank, 1 = second-sequence bank.
- wrIdx  input  IDX_W  hash index to write.
- wrData  input  VAL_W  min-hash value.
- start  input  1  request to stream the loaded signature pair.
- busy  output  1  high in STREAM and DONE.
- outValid  output  1  outFirst/outSecond carry a valid pair this cycle.
- outFirst  output  VAL_W  first-sequence min value at the current index.
- outSecond  output  VAL_W  second-sequence min value at the current index.
- outLast  output  1  high with outValid on index NUM_HASH-1.
- done  output  1  one-cycle pulse after the last pair.
- startErr  output  1  sticky: start was seen while a load was incomplete.
- wrDropped  output  1  sticky: a write was issued while busy.

Behaviour:
- Reset (rstN=1 at a clk edge):
  - State goes to IDLE.
  - Both banks' loaded masks are cleared; bank data contents are don't-care.
  - All outputs are 0, including outFirst, outSecond and both sticky flags.
  - Reset mid-STREAM aborts: outValid=0 from the next cycle, with no outLast and no done.
- Storage:
  - Two banks of NUM_HASH x VAL_W registers.
  - Each bank has a NUM_HASH-bit loaded mask.
- Writes, IDLE only:
  - wrEn=1 stores wrData into bank[wrSel][wrIdx] and sets that mask bit.
  - Overwriting an already-loaded entry is legal; the last write wins.
  - wrIdx >= NUM_HASH is ignored and sets no mask bit.
- Writes while busy: ignored, and wrDropped is set (sticky until reset).
- States:
  - IDLE:
    - start=1 with both masks all-ones at the start of the cycle: go to STREAM with index counter = 0.
    - A write in the same cycle as start is stored, but does not count toward that start's completeness check.
    - start=1 with either mask incomplete: stay in IDLE and set startErr (sticky).
  - STREAM:
    - Each cycle: outValid=1, outFirst=bankA[idx], outSecond=bankB[idx], outLast=(idx==NUM_HASH-1).
    - idx increments by 1 each cycle.
    - After the cycle with idx==NUM_HASH-1, go to DONE.
    - start is ignored in STREAM.
  - DONE (one cycle):
    - done=1, outValid=0.
    - Both loaded masks are cleared.
    - Return to IDLE.
- Outputs are registered.
  - With start sampled high at edge t, the first valid pair appears after edge t+1.
  - Pairs occupy exactly NUM_HASH consecutive cycles with no bubbles.
  - done is high in the cycle immediately after outLast.
- There is no backpressure: the downstream counter compares every outValid cycle.
- outFirst and outSecond hold 0 whenever outValid=0.
- Consequence: a new stream requires a full reload of both banks. Minimum turnaround is 2*NUM_HASH write cycles plus 1.
- Downstream warm-up: the counter ignores its first two cycles after reset. The earliest legal outValid is set by the load, at least 2*NUM_HASH+1 cycles after reset release, so it is always later than that window. This must not be relaxed.
- busy = (state != IDLE).

Test Plan:
- Load bankA[i]=i and bankB[i]=i for i=0..15, then pulse start -> 16 consecutive outValid cycles with outFirst=outSecond=0..15, outLast only on the 16th, done=1 on the next cycle, busy high for 17 cycles, startErr=0.
- Load bankB[i]=i for even i and i+100 for odd i, then stream -> pairs equal on exactly 8 indices. A downstream counter model reads 8.
- Load all entries except bankB[7], then pulse start -> stays IDLE, outValid never rises, startErr=1. Then write bankB[7] and pulse start -> normal 16-pair stream, with startErr still 1.
- Pulse wrEn (bankA[3]=0xDEAD) during STREAM cycle 5 -> stream data unchanged, wrDropped=1. After done, pulse start without reloading -> startErr=1, no stream.
- Assert rstN for one cycle during STREAM cycle 9 -> next cycle outValid=0, busy=0, no outLast or done. Then start immediately -> startErr=1, because the masks were cleared.
- Write bankA[15] twice (0x1 then 0x2), complete the load, and assert start in the same cycle as a rewrite of bankA[0]=0x55 -> streamed index 15 shows 0x2 and index 0 shows 0x55, with streaming starting on the next cycle.
